// File: rtl/mem_port_arb.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arb
//  Description : Shares memory port A between a core and a host.
//                The core always owns the port with zero added latency.
//                A single host request is held and issued only in a cycle
//                the core leaves the port idle. Host reads complete after a
//                fixed read latency.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_port_arb #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int MEM_ADDR_W = 13,
    parameter int RD_LAT     = 2,
    parameter int TO_MAX     = 63
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  core_en_i,
    input  logic                  core_wr_i,
    input  logic [ADDR_W-1:0]     core_addr_i,
    input  logic [DATA_W-1:0]     core_data_i,
    input  logic                  host_req_i,
    input  logic                  host_wr_i,
    input  logic [ADDR_W-1:0]     host_addr_i,
    input  logic [DATA_W-1:0]     host_data_i,
    output logic                  host_busy_o,
    output logic                  host_gnt_o,
    output logic                  host_err_o,
    output logic                  host_to_o,
    output logic                  host_rd_vld_o,
    output logic [DATA_W-1:0]     host_rd_data_o,
    output logic [MEM_ADDR_W-1:0] mem_addr_o,
    output logic                  mem_wr_o,
    output logic [DATA_W-1:0]     mem_data_o,
    input  logic [DATA_W-1:0]     mem_data_i
);

    // Wait counter and latency counter limits, sized to their registers.
    localparam logic [7:0] TO_LIM  = 8'(TO_MAX);
    localparam logic [2:0] LAT_LIM = 3'(RD_LAT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state;
    logic                    hold_wr;
    logic [MEM_ADDR_W-1:0]   hold_addr;
    logic [DATA_W-1:0]       hold_data;
    logic [MEM_ADDR_W-1:0]   last_addr;
    logic [DATA_W-1:0]       last_data;
    logic [7:0]              wait_cnt;
    logic [2:0]              lat_cnt;
    logic                    err_q;
    logic                    to_q;
    logic                    vld_q;
    logic [DATA_W-1:0]       rd_data_q;
    logic                    addr_oor;
    logic                    host_issue;

    // A host address is out of range when any bit above the memory address
    // field is set; the core simply drops those bits.
    generate
        if (ADDR_W > MEM_ADDR_W) begin : g_range_chk
            logic unused_core_hi;
            assign addr_oor       = |host_addr_i[ADDR_W-1:MEM_ADDR_W];
            assign unused_core_hi = ^core_addr_i[ADDR_W-1:MEM_ADDR_W];
        end else begin : g_no_range_chk
            assign addr_oor = 1'b0;
        end
    endgenerate

    // The held host access may only go out in a cycle the core is silent.
    assign host_issue = (state == PEND) && !core_en_i;

    // Port A mux: core first, then the held host access, else park.
    always_comb begin
        mem_addr_o = last_addr;
        mem_data_o = last_data;
        mem_wr_o   = 1'b0;
        if (core_en_i) begin
            mem_addr_o = core_addr_i[MEM_ADDR_W-1:0];
            mem_data_o = core_data_i;
            mem_wr_o   = core_wr_i;
        end else if (host_issue) begin
            mem_addr_o = hold_addr;
            mem_data_o = hold_data;
            mem_wr_o   = hold_wr;
        end
    end

    // Remember the last driven address/data so an idle port keeps them stable.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            last_addr <= '0;
            last_data <= '0;
        end else if (core_en_i || host_issue) begin
            last_addr <= mem_addr_o;
            last_data <= mem_data_o;
        end
    end

    // Host request state machine: capture, wait for a free port, return data.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            hold_wr   <= 1'b0;
            hold_addr <= '0;
            hold_data <= '0;
            wait_cnt  <= '0;
            lat_cnt   <= '0;
            err_q     <= 1'b0;
            to_q      <= 1'b0;
            vld_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            err_q <= 1'b0;
            vld_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (host_req_i) begin
                        hold_wr   <= host_wr_i;
                        hold_addr <= host_addr_i[MEM_ADDR_W-1:0];
                        hold_data <= host_data_i;
                        wait_cnt  <= '0;
                        if (addr_oor) begin
                            err_q <= 1'b1;
                        end else begin
                            state <= PEND;
                        end
                    end
                end
                PEND: begin
                    if (core_en_i) begin
                        // Blocked by the core: count toward the timeout flag.
                        if (wait_cnt != TO_LIM) begin
                            wait_cnt <= wait_cnt + 8'd1;
                            if ((wait_cnt + 8'd1) == TO_LIM) begin
                                to_q <= 1'b1;
                            end
                        end
                    end else begin
                        wait_cnt <= '0;
                        to_q     <= 1'b0;
                        if (hold_wr) begin
                            state <= IDLE;
                        end else begin
                            state   <= RESP;
                            lat_cnt <= 3'd1;
                            // Single-cycle memory: data is already on the bus.
                            if (LAT_LIM == 3'd1) begin
                                vld_q     <= 1'b1;
                                rd_data_q <= mem_data_i;
                            end
                        end
                    end
                end
                RESP: begin
                    // lat_cnt counts cycles since the grant; the valid pulse
                    // lands in the cycle where it equals the read latency.
                    if (lat_cnt == LAT_LIM) begin
                        state <= IDLE;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                        if ((lat_cnt + 3'd1) == LAT_LIM) begin
                            vld_q     <= 1'b1;
                            rd_data_q <= mem_data_i;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign host_busy_o    = (state != IDLE);
    assign host_gnt_o     = host_issue;
    assign host_err_o     = err_q;
    assign host_to_o      = to_q;
    assign host_rd_vld_o  = vld_q;
    assign host_rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arb
//  Description : Directed bench for mem_port_arb with a transaction-level
//                reference model and a per-cycle output comparison.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arb;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 16;
    localparam int MEM_ADDR_W = 13;
    localparam int RD_LAT     = 2;
    localparam int TO_MAX     = 63;
    localparam int MEM_WORDS  = 1 << MEM_ADDR_W;

    logic        clk;
    logic        rst;
    logic        core_en, core_wr, host_req, host_wr;
    logic [15:0] core_addr, core_data, host_addr, host_data;
    logic        host_busy_o, host_gnt_o, host_err_o, host_to_o, host_rd_vld_o;
    logic [15:0] host_rd_data_o;
    logic [12:0] mem_addr_o;
    logic        mem_wr_o;
    logic [15:0] mem_data_o;
    logic [15:0] ram_q;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arb #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_ADDR_W(MEM_ADDR_W),
        .RD_LAT(RD_LAT), .TO_MAX(TO_MAX)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .core_en_i(core_en), .core_wr_i(core_wr),
        .core_addr_i(core_addr), .core_data_i(core_data),
        .host_req_i(host_req), .host_wr_i(host_wr),
        .host_addr_i(host_addr), .host_data_i(host_data),
        .host_busy_o(host_busy_o), .host_gnt_o(host_gnt_o),
        .host_err_o(host_err_o), .host_to_o(host_to_o),
        .host_rd_vld_o(host_rd_vld_o), .host_rd_data_o(host_rd_data_o),
        .mem_addr_o(mem_addr_o), .mem_wr_o(mem_wr_o),
        .mem_data_o(mem_data_o), .mem_data_i(ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment memory: synchronous RAM, read data one cycle after address.
    logic [15:0] ram [0:MEM_WORDS-1];
    always @(posedge clk) begin
        if (mem_wr_o) ram[mem_addr_o] <= mem_data_o;
        ram_q <= ram[mem_addr_o];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic [15:0] exp_mem [0:MEM_WORDS-1];
    logic        m_ok = 1'b0;
    logic        m_pend, m_wr, m_err, m_to;
    logic [12:0] m_addr, m_last_addr;
    logic [15:0] m_data, m_last_data, m_rd, m_resp_data;
    int          m_wait, m_resp;

    always @(posedge clk) begin : p_model
        bit idle_now;
        bit issue;
        idle_now = !m_pend && (m_resp == 0);
        issue    = m_pend && !core_en;
        if (issue && !m_wr) m_resp_data = exp_mem[m_addr];
        if (core_en && core_wr)  exp_mem[core_addr[12:0]] = core_data;
        else if (issue && m_wr)  exp_mem[m_addr] = m_data;
        if (core_en) begin
            m_last_addr = core_addr[12:0];
            m_last_data = core_data;
        end else if (issue) begin
            m_last_addr = m_addr;
            m_last_data = m_data;
        end
        m_err = 1'b0;
        if (m_resp > 0) m_resp--;
        if (m_pend) begin
            if (core_en) begin
                if (m_wait < TO_MAX) m_wait++;
                if (m_wait == TO_MAX) m_to = 1'b1;
            end else begin
                m_pend = 1'b0;
                m_wait = 0;
                m_to   = 1'b0;
                if (!m_wr) m_resp = RD_LAT;
            end
        end else if (idle_now && host_req) begin
            if (int'(host_addr) >= MEM_WORDS) begin
                m_err = 1'b1;
            end else begin
                m_pend = 1'b1;
                m_wr   = host_wr;
                m_addr = host_addr[12:0];
                m_data = host_data;
                m_wait = 0;
            end
        end
        if (m_resp == 1) m_rd = m_resp_data;
        if (!rst) begin
            m_ok = 1'b1;   m_pend = 1'b0; m_wr = 1'b0;  m_err = 1'b0; m_to = 1'b0;
            m_addr = '0;   m_data = '0;   m_last_addr = '0; m_last_data = '0;
            m_rd = '0;     m_wait = 0;    m_resp = 0;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin : p_cmp
        logic [12:0] ea;
        logic [15:0] ed;
        logic        ew;
        if (m_ok) begin
            if (core_en) begin
                ea = core_addr[12:0]; ed = core_data; ew = core_wr;
            end else if (m_pend) begin
                ea = m_addr; ed = m_data; ew = m_wr;
            end else begin
                ea = m_last_addr; ed = m_last_data; ew = 1'b0;
            end
            chk("mdl_mem_addr", 32'(mem_addr_o), 32'(ea));
            chk("mdl_mem_data", 32'(mem_data_o), 32'(ed));
            chk("mdl_mem_wr",   32'(mem_wr_o),   32'(ew));
            chk("mdl_gnt",      32'(host_gnt_o), 32'(m_pend && !core_en));
            chk("mdl_busy",     32'(host_busy_o), 32'(m_pend || (m_resp > 0)));
            chk("mdl_err",      32'(host_err_o), 32'(m_err));
            chk("mdl_to",       32'(host_to_o),  32'(m_to));
            chk("mdl_vld",      32'(host_rd_vld_o), 32'(m_resp == 1));
            chk("mdl_rd_data",  32'(host_rd_data_o), 32'(m_rd));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_idle();
        core_en = 1'b0; core_wr = 1'b0; host_req = 1'b0; host_wr = 1'b0;
    endtask
    task automatic host(input logic wr, input logic [15:0] a, input logic [15:0] d);
        host_req = 1'b1; host_wr = wr; host_addr = a; host_data = d;
    endtask
    task automatic core(input logic wr, input logic [15:0] a, input logic [15:0] d);
        core_en = 1'b1; core_wr = wr; core_addr = a; core_data = d;
    endtask
    task automatic tick();
        @(posedge clk); #1;
    endtask
    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) begin
            ram[i] = '0;
            exp_mem[i] = '0;
        end
        rst = 1'b0;
        set_idle();
        core_addr = '0; core_data = '0; host_addr = '0; host_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        at_neg();
        chk("rst_busy",    32'(host_busy_o), 32'd0);
        chk("rst_to",      32'(host_to_o), 32'd0);
        chk("rst_rd_data", 32'(host_rd_data_o), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr_o), 32'd0);
        tick();

        // Host write 0x0010 <= 0xBEEF with the core idle.
        host(1'b1, 16'h0010, 16'hBEEF); tick();
        set_idle(); at_neg();
        chk("wr_gnt", 32'(host_gnt_o), 32'd1);
        chk("wr_mem_wr", 32'(mem_wr_o), 32'd1);
        chk("wr_mem_addr", 32'(mem_addr_o), 32'h0010);
        chk("wr_mem_data", 32'(mem_data_o), 32'hBEEF);
        tick();
        at_neg();
        chk("wr_idle_busy", 32'(host_busy_o), 32'd0);
        chk("wr_idle_wr", 32'(mem_wr_o), 32'd0);
        chk("wr_idle_addr_hold", 32'(mem_addr_o), 32'h0010);
        tick();

        // Host read back 0x0010.
        host(1'b0, 16'h0010, 16'h0000); tick();
        set_idle(); at_neg();
        chk("rd_gnt", 32'(host_gnt_o), 32'd1);
        chk("rd_mem_wr", 32'(mem_wr_o), 32'd0);
        tick(); at_neg();
        chk("rd_vld_early", 32'(host_rd_vld_o), 32'd0);
        chk("rd_busy", 32'(host_busy_o), 32'd1);
        tick(); at_neg();
        chk("rd_vld", 32'(host_rd_vld_o), 32'd1);
        chk("rd_data", 32'(host_rd_data_o), 32'hBEEF);
        tick(); at_neg();
        chk("rd_vld_after", 32'(host_rd_vld_o), 32'd0);
        chk("rd_busy_after", 32'(host_busy_o), 32'd0);
        tick();

        // Host read blocked by 10 core cycles; a second host request is ignored.
        host(1'b0, 16'h0010, 16'h0000); core(1'b0, 16'h0100, 16'h0000); tick();
        for (int k = 1; k <= 10; k++) begin
            set_idle();
            core(1'b1, 16'(16'hE300 + k), 16'(16'h1000 + k));
            if (k == 2) host(1'b1, 16'h0ABC, 16'h7777);
            at_neg();
            chk("blk_gnt", 32'(host_gnt_o), 32'd0);
            chk("blk_addr", 32'(mem_addr_o), 32'(16'h0300 + k));
            tick();
        end
        set_idle(); at_neg();
        chk("blk_rel_gnt", 32'(host_gnt_o), 32'd1);
        chk("blk_rel_addr", 32'(mem_addr_o), 32'h0010);
        tick(); tick(); at_neg();
        chk("blk_vld", 32'(host_rd_vld_o), 32'd1);
        chk("blk_data", 32'(host_rd_data_o), 32'hBEEF);
        tick();

        // Timeout: core holds the port for TO_MAX+5 cycles.
        set_idle(); host(1'b0, 16'h0305, 16'h0000); tick();
        for (int k = 1; k <= TO_MAX + 5; k++) begin
            set_idle(); core(1'b0, 16'h0000, 16'h0000);
            at_neg();
            if (k == TO_MAX)     chk("to_before", 32'(host_to_o), 32'd0);
            if (k == TO_MAX + 1) chk("to_set", 32'(host_to_o), 32'd1);
            tick();
        end
        set_idle(); at_neg();
        chk("to_gnt", 32'(host_gnt_o), 32'd1);
        chk("to_still_set", 32'(host_to_o), 32'd1);
        tick(); at_neg();
        chk("to_cleared", 32'(host_to_o), 32'd0);
        tick(); at_neg();
        chk("to_vld", 32'(host_rd_vld_o), 32'd1);
        chk("to_data", 32'(host_rd_data_o), 32'h1005);
        tick();

        // Core write collides with a would-be host write issue.
        set_idle(); host(1'b1, 16'h0400, 16'hAAAA); tick();
        set_idle(); core(1'b1, 16'h0400, 16'h5555); at_neg();
        chk("col_gnt", 32'(host_gnt_o), 32'd0);
        chk("col_core_data", 32'(mem_data_o), 32'h5555);
        chk("col_busy", 32'(host_busy_o), 32'd1);
        tick();
        set_idle(); at_neg();
        chk("col_host_gnt", 32'(host_gnt_o), 32'd1);
        chk("col_host_data", 32'(mem_data_o), 32'hAAAA);
        tick();
        host(1'b0, 16'h0400, 16'h0000); tick();
        set_idle(); tick(); tick(); at_neg();
        chk("col_rd_vld", 32'(host_rd_vld_o), 32'd1);
        chk("col_rd_data", 32'(host_rd_data_o), 32'hAAAA);
        tick();

        // Address range boundary.
        set_idle(); host(1'b1, 16'h2000, 16'h1234); tick();
        set_idle(); at_neg();
        chk("oor_err", 32'(host_err_o), 32'd1);
        chk("oor_busy", 32'(host_busy_o), 32'd0);
        chk("oor_gnt", 32'(host_gnt_o), 32'd0);
        chk("oor_mem_wr", 32'(mem_wr_o), 32'd0);
        tick(); at_neg();
        chk("oor_err_pulse", 32'(host_err_o), 32'd0);
        tick();
        host(1'b0, 16'hFFFF, 16'h0000); tick();
        set_idle(); at_neg();
        chk("oor_ffff_err", 32'(host_err_o), 32'd1);
        tick();
        host(1'b1, 16'h1FFF, 16'h4321); tick();
        set_idle(); at_neg();
        chk("top_err", 32'(host_err_o), 32'd0);
        chk("top_gnt", 32'(host_gnt_o), 32'd1);
        chk("top_addr", 32'(mem_addr_o), 32'h1FFF);
        tick();

        // Reset one cycle after a read grant discards the response.
        set_idle(); host(1'b0, 16'h0010, 16'h0000); tick();
        set_idle(); at_neg();
        chk("rr_gnt", 32'(host_gnt_o), 32'd1);
        tick();
        rst = 1'b0; tick();
        rst = 1'b1; at_neg();
        chk("rr_vld", 32'(host_rd_vld_o), 32'd0);
        chk("rr_busy", 32'(host_busy_o), 32'd0);
        chk("rr_rd_data", 32'(host_rd_data_o), 32'd0);
        chk("rr_mem_addr", 32'(mem_addr_o), 32'd0);
        chk("rr_mem_data", 32'(mem_data_o), 32'd0);
        tick(); at_neg();
        chk("rr_vld_late", 32'(host_rd_vld_o), 32'd0);
        tick();
        host(1'b0, 16'h1FFF, 16'h0000); tick();
        set_idle(); at_neg();
        chk("rr_new_gnt", 32'(host_gnt_o), 32'd1);
        tick(); tick(); at_neg();
        chk("rr_new_vld", 32'(host_rd_vld_o), 32'd1);
        chk("rr_new_data", 32'(host_rd_data_o), 32'h4321);
        tick();

        set_idle();
        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arb.md
MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 SHALL have parameter DATA_W, default 16, main memory data width (op-code width).
REQ-002 SHALL have parameter ADDR_W, default 16, core/host address width.
REQ-003 SHALL have parameter MEM_ADDR_W, default 13, main memory address width.
REQ-004 SHALL have parameter RD_LAT, default 2, memory read latency in cycles (range 1..4).
REQ-005 SHALL have parameter TO_MAX, default 63, host wait cycles before timeout flag (range 1..255).
REQ-006 Ports, in order:
  clk_i  in  1  the single clock; all logic on rising edge.
  rst_i  in  1  reset, synchronous, active-low.
  core_en_i  in  1  core memory access this cycle (read or write).
  core_wr_i  in  1  core write strobe.
  core_addr_i  in  ADDR_W  core address.
  core_data_i  in  DATA_W  core write data.
  host_req_i  in  1  host access request.
  host_wr_i  in  1  host write (1) / read (0), sampled with host_req_i.
  host_addr_i  in  ADDR_W  host address, sampled with host_req_i.
  host_data_i  in  DATA_W  host write data, sampled with host_req_i.
  host_busy_o  out  1  request held; new requests ignored.
  host_gnt_o  out  1  one-cycle pulse: host access issued to memory.
  host_err_o  out  1  one-cycle pulse: request rejected (address out of range).
  host_to_o  out  1  sticky: host waited TO_MAX cycles.
  host_rd_vld_o  out  1  one-cycle pulse: host read data valid.
  host_rd_data_o  out  DATA_W  host read data, held until next valid.
  mem_addr_o  out  MEM_ADDR_W  memory port A address.
  mem_wr_o  out  1  memory port A write enable.
  mem_data_o  out  DATA_W  memory port A write data.
  mem_data_i  in  DATA_W  memory port A read data.

Function
REQ-007 Core SHALL have absolute priority; core path to mem_* SHALL be combinational with zero added latency and never stalled.
REQ-008 When core_en_i=1: mem_addr_o=core_addr_i[MEM_ADDR_W-1:0], mem_wr_o=core_wr_i, mem_data_o=core_data_i.
REQ-009 FSM states IDLE, PEND, RESP; reset state IDLE.
REQ-010 IDLE, host_req_i=1: capture wr/addr/data into hold registers; if host_addr_i >= 2^MEM_ADDR_W pulse host_err_o next cycle and stay IDLE, else go PEND.
REQ-011 PEND, core_en_i=1: no host issue; wait counter increments, saturating at TO_MAX.
REQ-012 PEND, core_en_i=0: drive mem_* from hold registers (mem_wr_o=hold_wr), pulse host_gnt_o same cycle, clear wait counter and host_to_o; write -> IDLE, read -> RESP.
REQ-013 Issue SHALL occur no earlier than the cycle after capture.
REQ-014 RESP: host_rd_vld_o pulses exactly RD_LAT cycles after grant cycle, host_rd_data_o registered from mem_data_i in that cycle; then -> IDLE.
REQ-015 host_busy_o=1 in PEND and RESP; host_req_i SHALL be ignored in those states.
REQ-016 host_to_o SHALL set when wait counter reaches TO_MAX, remain set until next grant or reset; PEND continues (no abort).
REQ-017 Idle port (no core, no host issue): mem_wr_o=0, mem_addr_o and mem_data_o hold last driven values.
REQ-018 Core write in the same cycle as a host would-be issue: core write proceeds, host stays PEND (no lost or merged access).

Reset
REQ-019 rst_i=0 at a clock edge: FSM->IDLE, hold registers, wait counter, host_rd_data_o cleared to 0; all outputs 0; any pending/in-flight host access discarded with no gnt/vld.
REQ-020 Reset asserted mid-RESP SHALL suppress the pending host_rd_vld_o.

Verification
REQ-021 Host write addr 0x0010 data 0xBEEF, core idle -> gnt at T+1, mem_wr_o=1, mem_addr_o=0x0010; back to IDLE at T+2.
REQ-022 Host read addr 0x0010 after above, core idle, RD_LAT=2 -> gnt at T+1, host_rd_vld_o at T+3 with 0xBEEF.
REQ-023 Host read pending, core_en_i=1 for 10 cycles -> no gnt for 10 cycles; gnt first cycle core_en_i=0; mem_* reflected core throughout.
REQ-024 Host pending, core_en_i held 1 for TO_MAX+5 cycles -> host_to_o rises after TO_MAX wait cycles, clears on eventual gnt.
REQ-025 Host request addr 0x2000 (MEM_ADDR_W=13) -> host_err_o pulse, no gnt, no mem write, host_busy_o stays 0.
REQ-026 rst_i=0 one cycle after read grant -> no host_rd_vld_o, all outputs 0, next request accepted normally.
